pwm_decoder: RTL

- Measures an incoming PWM waveform, the receive-side counterpart of the team's PWM generators.
- Synchronises `pwm_in` into the `clk` domain and measures high time and period in clock cycles, one full period at a time.
- Recovers the 3-bit duty code from the high time. The generator encoding is high = code*2^(CBITS-4) + 2^(CBITS-5).
- Flags stuck-high and stuck-low inputs. Used on loopback and inter-board links to check PWM sources.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_edge_sync.sv | 43 ++++
 rtl/pwm_decoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the PWM generator/decoder pair
package pwm_pkg;

    localparam int CBITS_DEFAULT = 10;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        HIGH    = 2'd1,
        LOW     = 2'd2
    } pwm_state_t;

    function automatic int tmax_of(input int cbits);
        return (1 << (cbits + 1)) - 1;
    endfunction

    function automatic int duty_shift_of(input int cbits);
        return cbits - 4;
    endfunction

    localparam int TMAX       = tmax_of(CBITS_DEFAULT);
    localparam int DUTY_SHIFT = duty_shift_of(CBITS_DEFAULT);

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - pwm_in synchroniser, edge detector and post-reset settling window
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall,
    output logic settled
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int SETTLE = STAGES + 1;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [SW-1:0]     settle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            settle_cnt <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pwm_in};
            prev_q <= sync_q[STAGES-1];
            if (settle_cnt != SETTLE_C) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // prev only reflects the pin once the whole chain has refilled, so edges wait for that
    assign s       = sync_q[STAGES-1];
    assign settled = (settle_cnt == SETTLE_C);
    assign rise    = settled & s & ~prev_q;
    assign fall    = settled & ~s & prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - measures PWM high time and period, recovers duty code, flags stuck inputs
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CBITS       = CBITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CBITS:0]   high_time,
    output logic [CBITS:0]   period,
    output logic [2:0]       duty_code,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CBITS:0] CNT_MAX = (CBITS + 1)'(tmax_of(CBITS));
    localparam logic [CBITS:0] CNT_ONE = (CBITS + 1)'(1);
    localparam int             SHIFT   = duty_shift_of(CBITS);

    logic s, rise, fall, settled;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .pwm_in  (pwm_in),
        .s       (s),
        .rise    (rise),
        .fall    (fall),
        .settled (settled)
    );

    pwm_state_t     state, state_nxt;
    logic [CBITS:0] hi_cnt, per_cnt, hi_nxt, per_nxt;
    logic [CBITS:0] high_time_nxt, period_nxt;
    logic [2:0]     duty_nxt;
    logic           meas_nxt, locked_nxt, stuck_high_nxt, stuck_low_nxt;
    logic           timeout, latch;
    logic [CBITS:0] per_inc, hi_inc;

    assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + 1'b1;
    assign hi_inc  = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + 1'b1;

    // an edge in the same cycle always beats the timeout
    assign timeout = settled && (per_cnt == CNT_MAX) && !(rise || fall);
    assign latch   = settled && (state == LOW) && rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACQUIRE;
            hi_cnt     <= '0;
            per_cnt    <= '0;
            high_time  <= '0;
            period     <= '0;
            duty_code  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            state      <= state_nxt;
            hi_cnt     <= hi_nxt;
            per_cnt    <= per_nxt;
            high_time  <= high_time_nxt;
            period     <= period_nxt;
            duty_code  <= duty_nxt;
            meas_valid <= meas_nxt;
            locked     <= locked_nxt;
            stuck_high <= stuck_high_nxt;
            stuck_low  <= stuck_low_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (settled) begin
            case (state)
                ACQUIRE: if (rise) state_nxt = HIGH;
                HIGH: begin
                    if (fall)         state_nxt = LOW;
                    else if (timeout) state_nxt = ACQUIRE;
                end
                LOW: begin
                    if (rise)         state_nxt = HIGH;
                    else if (timeout) state_nxt = ACQUIRE;
                end
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

    always_comb begin
        hi_nxt         = hi_cnt;
        per_nxt        = per_cnt;
        high_time_nxt  = high_time;
        period_nxt     = period;
        duty_nxt       = duty_code;
        meas_nxt       = 1'b0;
        locked_nxt     = locked;
        stuck_high_nxt = stuck_high;
        stuck_low_nxt  = stuck_low;
        if (settled) begin
            case (state)
                ACQUIRE: begin
                    // idle counter; a fall proves the input is alive, so restart it
                    if (rise) begin
                        hi_nxt  = CNT_ONE;
                        per_nxt = CNT_ONE;
                    end else if (fall) begin
                        per_nxt = '0;
                    end else begin
                        per_nxt = per_inc;
                    end
                end
                HIGH: begin
                    per_nxt = per_inc;
                    if (!fall) hi_nxt = hi_inc;
                end
                LOW: begin
                    if (rise) begin
                        hi_nxt  = CNT_ONE;
                        per_nxt = CNT_ONE;
                    end else begin
                        per_nxt = per_inc;
                    end
                end
                default: begin
                    hi_nxt  = '0;
                    per_nxt = '0;
                end
            endcase
            if (latch) begin
                high_time_nxt  = hi_cnt;
                period_nxt     = per_cnt;
                duty_nxt       = (hi_cnt[CBITS:CBITS-1] != 2'b00) ? 3'd7 : hi_cnt[SHIFT+2:SHIFT];
                meas_nxt       = 1'b1;
                locked_nxt     = 1'b1;
                stuck_high_nxt = 1'b0;
                stuck_low_nxt  = 1'b0;
            end
            if (timeout) begin
                locked_nxt     = 1'b0;
                stuck_high_nxt = s;
                stuck_low_nxt  = ~s;
            end
        end
    end

endmodule
